// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment readback monitor.
//   - Active-low HEX0 segment patterns for 0-F and blank (gfedcba order).
//   - Monitor FSM state enum.
//   - seg7_decode(): pattern -> {valid, digit}.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOCKED
    } monitor_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } decode_t;

    function automatic decode_t seg7_decode(input logic [6:0] pattern);
        decode_t result;
        result = '{valid: 1'b1, digit: 4'd0};
        case (pattern)
            SEG_0:   result.digit = 4'h0;
            SEG_1:   result.digit = 4'h1;
            SEG_2:   result.digit = 4'h2;
            SEG_3:   result.digit = 4'h3;
            SEG_4:   result.digit = 4'h4;
            SEG_5:   result.digit = 4'h5;
            SEG_6:   result.digit = 4'h6;
            SEG_7:   result.digit = 4'h7;
            SEG_8:   result.digit = 4'h8;
            SEG_9:   result.digit = 4'h9;
            SEG_A:   result.digit = 4'hA;
            SEG_B:   result.digit = 4'hB;
            SEG_C:   result.digit = 4'hC;
            SEG_D:   result.digit = 4'hD;
            SEG_E:   result.digit = 4'hE;
            SEG_F:   result.digit = 4'hF;
            default: result.valid = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational decode of one active-low segment pattern.
// Ports:
//   pattern  in   7  segment pattern, bit0=a .. bit6=g, 0 = lit
//   digit    out  4  decoded digit (0 when not decodable)
//   valid    out  1  pattern is one of the 16 digit glyphs
//   blank    out  1  pattern is all segments off
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       valid,
    output logic       blank
);

    decode_t decoded;

    assign decoded = seg7_decode(pattern);
    assign digit   = decoded.digit;
    assign valid   = decoded.valid;
    assign blank   = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_readback_monitor.sv
// seg7_readback_monitor: watches the HEX segment bus, recovers the shown digit
// after glitch filtering, checks it counts modulo MAX_DIGIT+1 and measures the
// cycle distance between successive digit changes.
// Ports:
//   CLOCK_50         in   1      system clock, rising edge
//   reset            in   1      synchronous, active-low reset
//   seg_in           in   7      segment bus (asynchronous), 0 = segment lit
//   digit_out        out  4      last accepted digit
//   digit_valid      out  1      digit_out currently holds a decoded digit
//   new_digit        out  1      one-cycle pulse on digit acceptance
//   seq_error        out  1      sticky: sequence broken
//   invalid_pattern  out  1      sticky: stable undecodable pattern seen
//   period           out  CNT_W  cycles between the last two new_digit pulses
//   period_valid     out  1      period holds a measurement
module seg7_readback_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_DIGIT     = 9,
    parameter int CNT_W         = 26
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit_out,
    output logic             digit_valid,
    output logic             new_digit,
    output logic             seq_error,
    output logic             invalid_pattern,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    logic [6:0]       sync1;
    logic [6:0]       sync2;
    logic [6:0]       candidate;
    logic [7:0]       stable_cnt;
    logic [6:0]       accepted;
    monitor_state_t   state;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] period_next;
    logic             seen_digit;

    logic [3:0]       dec_digit;
    logic             dec_valid;
    logic             dec_blank;
    logic             match;
    logic             stable_enough;
    logic [3:0]       expected_next;
    logic             out_of_sequence;

    seg7_pattern_decode u_decode (
        .pattern (candidate),
        .digit   (dec_digit),
        .valid   (dec_valid),
        .blank   (dec_blank)
    );

    assign match = (sync2 == candidate);

    // The sample that loaded the candidate plus the matching sample in sync2
    // right now are two identical samples beyond what stable_cnt has counted,
    // so acceptance happens exactly when STABLE_CYCLES samples have agreed.
    assign stable_enough = match &&
                           (({1'b0, stable_cnt} + 9'd2) >= 9'(STABLE_CYCLES));

    assign period_next   = (&period_cnt) ? period_cnt : period_cnt + 1'b1;
    assign expected_next = (digit_out == 4'(MAX_DIGIT)) ? 4'd0 : digit_out + 4'd1;
    assign out_of_sequence = (dec_digit != expected_next) ||
                             (dec_digit > 4'(MAX_DIGIT));

    // Input path: two-flop synchronizer, candidate tracking and a saturating
    // count of how long the candidate has stayed unchanged.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            sync1      <= SEG_BLANK;
            sync2      <= SEG_BLANK;
            candidate  <= SEG_BLANK;
            stable_cnt <= '0;
        end else begin
            sync1     <= seg_in;
            sync2     <= sync1;
            candidate <= sync2;
            if (!match) begin
                stable_cnt <= '0;
            end else if (stable_cnt != 8'(STABLE_CYCLES)) begin
                stable_cnt <= stable_cnt + 8'd1;
            end
        end
    end

    // Acceptance FSM with all monitor outputs registered. A pattern returning
    // to the accepted one mid-settle is a glitch and is dropped silently.
    // Blank and undecodable patterns clear digit_valid, which is also the
    // sequence history, so the next digit after them is never checked.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state           <= ST_IDLE;
            accepted        <= SEG_BLANK;
            digit_out       <= '0;
            digit_valid     <= 1'b0;
            new_digit       <= 1'b0;
            seq_error       <= 1'b0;
            invalid_pattern <= 1'b0;
            period          <= '0;
            period_valid    <= 1'b0;
            period_cnt      <= '0;
            seen_digit      <= 1'b0;
        end else begin
            new_digit  <= 1'b0;
            period_cnt <= period_next;
            case (state)
                ST_IDLE, ST_LOCKED: begin
                    if (sync2 != accepted) begin
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (sync2 == accepted) begin
                        state <= ST_LOCKED;
                    end else if (stable_enough) begin
                        state    <= ST_LOCKED;
                        accepted <= candidate;
                        if (dec_valid) begin
                            digit_out   <= dec_digit;
                            digit_valid <= 1'b1;
                            new_digit   <= 1'b1;
                            if (digit_valid && out_of_sequence) begin
                                seq_error <= 1'b1;
                            end
                            period_cnt <= '0;
                            if (seen_digit) begin
                                period       <= period_next;
                                period_valid <= 1'b1;
                            end
                            seen_digit <= 1'b1;
                        end else if (dec_blank) begin
                            digit_valid <= 1'b0;
                        end else begin
                            invalid_pattern <= 1'b1;
                            digit_valid     <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_readback_monitor.sv
// tb_seg7_readback_monitor: self-checking bench for seg7_readback_monitor.
// A behavioural model tracks how long each synchronized pattern has been
// held and which pattern was last accepted; it is compared against every
// DUT output after every clock edge. Directed sequences add literal checks.
module tb_seg7_readback_monitor;

    localparam int STABLE    = 4;
    localparam int MAXD      = 9;
    localparam int CW        = 26;
    localparam longint PMAX  = (64'd1 << CW) - 1;

    logic          CLOCK_50;
    logic          reset;
    logic [6:0]    seg_in;
    logic [3:0]    digit_out;
    logic          digit_valid;
    logic          new_digit;
    logic          seq_error;
    logic          invalid_pattern;
    logic [CW-1:0] period;
    logic          period_valid;

    int checks   = 0;
    int failures = 0;
    int pulse_count = 0;

    seg7_readback_monitor #(
        .STABLE_CYCLES (STABLE),
        .MAX_DIGIT     (MAXD),
        .CNT_W         (CW)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .seg_in          (seg_in),
        .digit_out       (digit_out),
        .digit_valid     (digit_valid),
        .new_digit       (new_digit),
        .seq_error       (seq_error),
        .invalid_pattern (invalid_pattern),
        .period          (period),
        .period_valid    (period_valid)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Glyph table for digits 0-F, written out independently of the design.
    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Returns the digit 0..15, 16 for blank, -1 for an undecodable pattern.
    function automatic int decode_model(input logic [6:0] p);
        if (p == 7'h7F) return 16;
        for (int i = 0; i < 16; i++) begin
            if (glyphs[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model state
    logic [6:0]  m_hist1 = 7'h7F, m_hist2 = 7'h7F, m_accepted = 7'h7F, m_run_val = 7'h7F;
    logic [6:0]  m_s2;
    int          m_run_len = 0;
    int          m_code;
    int          m_next;
    longint      edge_no = 0, m_last_edge = 0, m_dist;
    bit          m_seen_digit = 0;
    logic [3:0]  exp_digit = 0;
    logic        exp_valid = 0, exp_new = 0, exp_seq = 0, exp_inv = 0, exp_pv = 0;
    logic [CW-1:0] exp_period = 0;

    // Model update on every edge, then compare all outputs once they settle.
    always @(posedge CLOCK_50) begin
        edge_no++;
        if (!reset) begin
            m_hist1 = 7'h7F; m_hist2 = 7'h7F; m_accepted = 7'h7F;
            m_run_val = 7'h7F; m_run_len = 0; m_seen_digit = 0;
            exp_digit = 0; exp_valid = 0; exp_new = 0; exp_seq = 0;
            exp_inv = 0; exp_pv = 0; exp_period = 0;
        end else begin
            m_s2 = m_hist2;
            m_hist2 = m_hist1;
            m_hist1 = seg_in;
            if (m_s2 == m_run_val) m_run_len++;
            else begin
                m_run_val = m_s2;
                m_run_len = 1;
            end
            exp_new = 0;
            if (m_s2 != m_accepted && m_run_len >= STABLE) begin
                m_accepted = m_s2;
                m_code = decode_model(m_s2);
                if (m_code >= 0 && m_code < 16) begin
                    if (exp_valid) begin
                        m_next = (int'(exp_digit) == MAXD) ? 0 : int'(exp_digit) + 1;
                        if (m_code != m_next || m_code > MAXD) exp_seq = 1;
                    end
                    exp_digit = 4'(m_code);
                    exp_valid = 1;
                    exp_new = 1;
                    if (m_seen_digit) begin
                        m_dist = edge_no - m_last_edge;
                        exp_period = CW'((m_dist > PMAX) ? PMAX : m_dist);
                        exp_pv = 1;
                    end
                    m_seen_digit = 1;
                    m_last_edge = edge_no;
                end else if (m_code == 16) begin
                    exp_valid = 0;
                end else begin
                    exp_inv = 1;
                    exp_valid = 0;
                end
            end
        end
        #1;
        checkOutput("model_digit_out", 32'(digit_out), 32'(exp_digit));
        checkOutput("model_digit_valid", 32'(digit_valid), 32'(exp_valid));
        checkOutput("model_new_digit", 32'(new_digit), 32'(exp_new));
        checkOutput("model_seq_error", 32'(seq_error), 32'(exp_seq));
        checkOutput("model_invalid_pattern", 32'(invalid_pattern), 32'(exp_inv));
        checkOutput("model_period", 32'(period), 32'(exp_period));
        checkOutput("model_period_valid", 32'(period_valid), 32'(exp_pv));
        if (new_digit === 1'b1) pulse_count++;
    end

    // Drive a pattern from a falling edge and hold it for the given number of
    // rising edges; returns shortly after the last of them.
    task automatic applyStimulus(input logic [6:0] p, input int cycles);
        @(negedge CLOCK_50);
        seg_in = p;
        repeat (cycles) @(posedge CLOCK_50);
        #2;
    endtask

    task automatic doReset();
        @(negedge CLOCK_50);
        reset = 1'b0;
        seg_in = 7'h7F;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b1;
    endtask

    logic [6:0] count_seq [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                   7'h02, 7'h78, 7'h00, 7'h10, 7'h40};
    logic [6:0] pool [20] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                              7'h7F, 7'h7E, 7'h5A, 7'h40};
    int pulses_before;

    initial begin
        reset  = 1'b0;
        seg_in = 7'h7F;
        repeat (2) @(posedge CLOCK_50);
        #2;
        checkOutput("reset_digit_out", 32'(digit_out), 0);
        checkOutput("reset_digit_valid", 32'(digit_valid), 0);
        checkOutput("reset_period_valid", 32'(period_valid), 0);
        @(negedge CLOCK_50);
        reset = 1'b1;

        // First acceptance: pulse on the 6th edge counting the sampling edge.
        @(negedge CLOCK_50);
        seg_in = 7'h40;
        for (int e = 1; e <= 6; e++) begin
            @(posedge CLOCK_50);
            #2;
            checkOutput($sformatf("latency_new_digit_e%0d", e), 32'(new_digit), (e == 6) ? 1 : 0);
        end
        checkOutput("first_digit_out", 32'(digit_out), 0);
        checkOutput("first_digit_valid", 32'(digit_valid), 1);
        checkOutput("first_seq_error", 32'(seq_error), 0);
        checkOutput("first_period_valid", 32'(period_valid), 0);

        // Short glitch to 1 is rejected.
        applyStimulus(7'h40, 4);
        pulses_before = pulse_count;
        applyStimulus(7'h79, 3);
        applyStimulus(7'h40, 12);
        checkOutput("glitch_pulses", 32'(pulse_count - pulses_before), 0);
        checkOutput("glitch_digit_out", 32'(digit_out), 0);

        // Full count 0..9 and wrap to 0.
        doReset();
        pulses_before = pulse_count;
        for (int i = 0; i < 11; i++) applyStimulus(count_seq[i], 10);
        checkOutput("count_pulses", 32'(pulse_count - pulses_before), 11);
        checkOutput("count_period", 32'(period), 10);
        checkOutput("count_period_valid", 32'(period_valid), 1);
        checkOutput("count_seq_error", 32'(seq_error), 0);
        checkOutput("count_digit_out", 32'(digit_out), 0);

        // Skip 0 -> 2 sets a sticky sequence error.
        doReset();
        applyStimulus(7'h40, 10);
        applyStimulus(7'h24, 10);
        checkOutput("skip_seq_error", 32'(seq_error), 1);
        checkOutput("skip_digit_out", 32'(digit_out), 2);
        applyStimulus(7'h30, 10);
        checkOutput("skip_sticky_seq_error", 32'(seq_error), 1);

        // Undecodable pattern clears history; next digit not checked.
        doReset();
        applyStimulus(7'h30, 10);
        pulses_before = pulse_count;
        applyStimulus(7'h7E, 10);
        checkOutput("invalid_flag", 32'(invalid_pattern), 1);
        checkOutput("invalid_digit_valid", 32'(digit_valid), 0);
        checkOutput("invalid_pulses", 32'(pulse_count - pulses_before), 0);
        applyStimulus(7'h12, 10);
        checkOutput("after_invalid_digit_out", 32'(digit_out), 5);
        checkOutput("after_invalid_seq_error", 32'(seq_error), 0);

        // Reset while locked with a period measurement.
        doReset();
        applyStimulus(7'h24, 10);
        applyStimulus(7'h30, 10);
        checkOutput("pre_reset_digit_out", 32'(digit_out), 3);
        checkOutput("pre_reset_period_valid", 32'(period_valid), 1);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(posedge CLOCK_50);
        #2;
        checkOutput("rst_digit_out", 32'(digit_out), 0);
        checkOutput("rst_digit_valid", 32'(digit_valid), 0);
        checkOutput("rst_period", 32'(period), 0);
        checkOutput("rst_period_valid", 32'(period_valid), 0);
        @(negedge CLOCK_50);
        reset = 1'b1;
        seg_in = 7'h79;
        for (int e = 1; e <= 6; e++) begin
            @(posedge CLOCK_50);
            #2;
            checkOutput($sformatf("post_reset_new_digit_e%0d", e), 32'(new_digit), (e == 6) ? 1 : 0);
        end

        // New candidate mid-settle restarts the count; only the latest wins.
        applyStimulus(7'h79, 4);
        pulses_before = pulse_count;
        applyStimulus(7'h24, 2);
        applyStimulus(7'h30, 10);
        checkOutput("restart_pulses", 32'(pulse_count - pulses_before), 1);
        checkOutput("restart_digit_out", 32'(digit_out), 3);

        // Reset mid-settle, then a mixed stream checked by the model alone.
        applyStimulus(7'h19, 3);
        doReset();
        for (int i = 0; i < 80; i++) begin
            applyStimulus(pool[$urandom_range(0, 19)], $urandom_range(1, 8));
        end
        applyStimulus(7'h40, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_readback_monitor.md
# seg7_readback_monitor

Decodes a 7-segment drive bus (active-low, HEX0 format) back into a 4-bit digit, filters glitches, and checks the recovered digits for a correct modulo-(MAX_DIGIT+1) counting sequence. It also measures the cycle period between successive digit changes. It sits beside the seconds-counter/HEX driver path as a self-check monitor, watching the segment bus the display encoder produces.

## Interface
- STABLE_CYCLES, 4, consecutive identical synchronized samples required to accept a pattern (legal range 2..255)
- MAX_DIGIT, 9, last digit of the expected sequence before wrap to 0
- CNT_W, 26, width of the period counter
- CLOCK_50  input  1  system clock, all logic on the rising edge
- reset  input  1  synchronous, active-low reset
- seg_in  input  7  segment bus, bit0=a … bit6=g, 0 = segment lit; asynchronous to CLOCK_50
- digit_out  output  4  last accepted decoded digit
- digit_valid  output  1  digit_out holds a decoded digit; low after reset, a blank pattern, or an invalid pattern
- new_digit  output  1  one-cycle pulse when a new digit is accepted
- seq_error  output  1  sticky: an accepted digit broke the sequence
- invalid_pattern  output  1  sticky: a stable, non-blank, undecodable pattern was seen
- period  output  CNT_W  cycles between the last two new_digit pulses
- period_valid  output  1  period holds a measurement (at least two accepts since reset)

## Operation
- Decode table, in gfedcba order, hex values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E. Blank = 7F.
- Input path:
  - seg_in passes a 2-flop synchronizer (s1, s2), both reset to 7F.
  - A candidate register tracks s2.
  - A stability counter clears whenever s2 differs from the candidate, and otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - IDLE (reset state, nothing accepted).
  - SETTLE (candidate differs from the accepted pattern, counting).
  - LOCKED (candidate equals the accepted pattern).
- FSM transitions:
  - LOCKED/IDLE → SETTLE when s2 changes away from the accepted pattern.
  - SETTLE → LOCKED when the stability count reaches STABLE_CYCLES. This is the acceptance edge.
  - SETTLE → LOCKED without acceptance if s2 returns to the accepted pattern before the count reaches STABLE_CYCLES (glitch rejected).
- Acceptance of a decodable pattern:
  - digit_out is loaded, digit_valid=1 and new_digit pulses.
  - If a previous valid digit exists, seq_error is set when the new digit ≠ (prev==MAX_DIGIT ? 0 : prev+1).
  - Decodable digits above MAX_DIGIT always set seq_error when a previous digit exists.
- Acceptance of blank: digit_valid=0, no pulse, no error, and sequence history is cleared.
- Acceptance of an undecodable pattern: invalid_pattern=1, digit_valid=0, no pulse, and sequence history is cleared. The next digit is therefore never sequence-checked.
- Period measurement:
  - A free-running counter clears on each new_digit and saturates at all-ones.
  - On each new_digit after the first, period is loaded with the cycle distance from the previous new_digit, and period_valid=1.
- Sticky flags clear only on reset.

## Timing
- Reset values: digit_out=0, digit_valid=0, new_digit=0, seq_error=0, invalid_pattern=0, period=0, period_valid=0; FSM in IDLE; synchronizer and candidate at 7F.
- Reset low at any edge, including mid-SETTLE, returns every register to its reset value on that edge.
- Latency: seg_in first sampled at edge k and held ⇒ new_digit high in the cycle after edge k+1+STABLE_CYCLES. With the default, that is 6 edges after first sampling.
- A change held fewer than STABLE_CYCLES synchronized cycles produces no output change.
- A new candidate arriving mid-SETTLE restarts the count; only the latest pattern can be accepted.
- Period saturation: at all-ones, the counter holds; period then reports all-ones.

## Structure
- Package seg7_pkg:
  - 7-bit pattern constants for 0–F and blank.
  - decode function returning {valid, digit}.
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern → 4-bit digit plus valid/blank flags. Instantiated once on the candidate register.

## Test plan
- Reset, then hold seg_in=40 → new_digit at edge 6, digit_out=0, digit_valid=1, seq_error=0, period_valid=0.
- Locked at 0; apply 79 for 3 cycles, then 40 → no new_digit, digit_out stays 0.
- Step 40,79,24,30,19,12,02,78,00,10,40, each held 10 cycles → 11 pulses, period=10, period_valid=1, seq_error=0, digit_out=0 after the wrap.
- 40 then 24 (0→2) → seq_error=1, digit_out=2; seq_error remains 1 after a subsequent 30.
- Hold 7E → invalid_pattern=1, digit_valid=0, no pulse; then 12 (5) → digit_out=5, seq_error stays 0.
- LOCKED on 3 with period_valid=1; reset low for one edge → all outputs 0 next cycle; 79 then takes a full 6 edges to accept.
